// File: rtl/xvga_pkg.sv
// Shared timing constants for the XGA (1024x768 @ 60 Hz, 65 MHz) video timing generator.
package xvga_pkg;

  localparam int unsigned XGA_H_ACTIVE = 1024;
  localparam int unsigned XGA_H_FP     = 24;
  localparam int unsigned XGA_H_SYNC   = 136;
  localparam int unsigned XGA_H_BP     = 160;

  localparam int unsigned XGA_V_ACTIVE = 768;
  localparam int unsigned XGA_V_FP     = 3;
  localparam int unsigned XGA_V_SYNC   = 6;
  localparam int unsigned XGA_V_BP     = 29;

  localparam int unsigned XGA_H_TOTAL      = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
  localparam int unsigned XGA_V_TOTAL      = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;
  localparam int unsigned XGA_H_SYNC_START = XGA_H_ACTIVE + XGA_H_FP;
  localparam int unsigned XGA_H_SYNC_END   = XGA_H_SYNC_START + XGA_H_SYNC;
  localparam int unsigned XGA_V_SYNC_START = XGA_V_ACTIVE + XGA_V_FP;
  localparam int unsigned XGA_V_SYNC_END   = XGA_V_SYNC_START + XGA_V_SYNC;

  // 1343 < 2048 and 805 < 1024
  localparam int unsigned H_CNT_W = 11;
  localparam int unsigned V_CNT_W = 10;

endpackage

// File: rtl/xvga_timing_if.sv
// Video timing bundle: pixel/line counters plus sync and blanking flags.
interface xvga_timing_if;
  import xvga_pkg::*;

  logic [H_CNT_W-1:0] hcount;
  logic [V_CNT_W-1:0] vcount;
  logic               hsync;
  logic               vsync;
  logic               blank;

  modport master (output hcount, vcount, hsync, vsync, blank);
  modport slave  (input  hcount, vcount, hsync, vsync, blank);

endinterface

// File: rtl/xvga_timing_sync_axis_counter.sv
// One timing axis: wrapping counter with registered sync and blank flags.
module sync_axis_counter #(
  parameter int unsigned ACTIVE = 1024,
  parameter int unsigned FP     = 24,
  parameter int unsigned SYNC   = 136,
  parameter int unsigned BP     = 160,
  parameter int unsigned WIDTH  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             blank
);

  localparam logic [WIDTH-1:0] LAST       = WIDTH'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [WIDTH-1:0] ACTIVE_END = WIDTH'(ACTIVE);
  localparam logic [WIDTH-1:0] SYNC_START = WIDTH'(ACTIVE + FP);
  localparam logic [WIDTH-1:0] SYNC_END   = WIDTH'(ACTIVE + FP + SYNC);

  logic [WIDTH-1:0] count_next;

  // Combinational so the next axis can advance on the same edge this one wraps.
  assign wrap = en && (count == LAST);

  always_comb begin
    count_next = count;
    if (wrap) begin
      count_next = '0;
    end else if (en) begin
      count_next = count + WIDTH'(1);
    end
  end

  // Flags are decoded from the next count so they land in the same cycle as it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      sync  <= 1'b0;
      blank <= 1'b0;
    end else begin
      count <= count_next;
      sync  <= (count_next >= SYNC_START) && (count_next < SYNC_END);
      blank <= (count_next >= ACTIVE_END);
    end
  end

endmodule

// File: rtl/xvga_timing.sv
// Video timing generator: horizontal axis free-runs, vertical axis steps on each line wrap.
module xvga_timing
  import xvga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = XGA_H_ACTIVE,
  parameter int unsigned H_FP     = XGA_H_FP,
  parameter int unsigned H_SYNC   = XGA_H_SYNC,
  parameter int unsigned H_BP     = XGA_H_BP,
  parameter int unsigned V_ACTIVE = XGA_V_ACTIVE,
  parameter int unsigned V_FP     = XGA_V_FP,
  parameter int unsigned V_SYNC   = XGA_V_SYNC,
  parameter int unsigned V_BP     = XGA_V_BP
) (
  input  logic          vclock,
  input  logic          reset_n,
  xvga_timing_if.master vid
);

  logic h_wrap;
  logic h_blank;
  logic v_blank;
  logic v_wrap_unused;

  sync_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .WIDTH  (H_CNT_W)
  ) u_h_axis (
    .clk    (vclock),
    .rst_n  (reset_n),
    .en     (1'b1),
    .count  (vid.hcount),
    .wrap   (h_wrap),
    .sync   (vid.hsync),
    .blank  (h_blank)
  );

  sync_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .WIDTH  (V_CNT_W)
  ) u_v_axis (
    .clk    (vclock),
    .rst_n  (reset_n),
    .en     (h_wrap),
    .count  (vid.vcount),
    .wrap   (v_wrap_unused),
    .sync   (vid.vsync),
    .blank  (v_blank)
  );

  // Both inputs are flops, so blank stays aligned with the counters.
  assign vid.blank = h_blank | v_blank;

endmodule

// File: tb/tb_xvga_timing.sv
// Bench for xvga_timing: XGA instance for line-level edges, reduced-geometry instance for frame behaviour.
module tb_xvga_timing;
  import xvga_pkg::*;

  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 6;
  localparam int S_VA = 10, S_VF = 2, S_VS = 3, S_VB = 4;
  localparam int S_HT = 28, S_VT = 19, S_FRAME = 532;
  localparam int X_HT = 1344;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        bl;
  } vid_t;

  logic   vclock        = 1'b0;
  logic   reset_xga_n   = 1'b0;
  logic   reset_small_n = 1'b0;
  longint t_xga         = 0;
  longint t_small       = 0;
  int     n_cmp         = 0;
  int     n_err         = 0;

  xvga_timing_if vid_xga();
  xvga_timing_if vid_small();

  xvga_timing dut_xga (
    .vclock  (vclock),
    .reset_n (reset_xga_n),
    .vid     (vid_xga)
  );

  xvga_timing #(
    .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
  ) dut_small (
    .vclock  (vclock),
    .reset_n (reset_small_n),
    .vid     (vid_small)
  );

  vid_t got_xga;
  vid_t got_small;
  assign got_xga   = {vid_xga.hcount, vid_xga.vcount, vid_xga.hsync, vid_xga.vsync, vid_xga.blank};
  assign got_small = {vid_small.hcount, vid_small.vcount, vid_small.hsync, vid_small.vsync, vid_small.blank};

  always #5 vclock = ~vclock;

  // Elapsed running cycles since the last reset edge.
  always @(posedge vclock) begin
    t_xga   <= reset_xga_n   ? t_xga + 1   : 0;
    t_small <= reset_small_n ? t_small + 1 : 0;
  end

  function automatic vid_t model(input longint t, input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb);
    int   ht;
    int   vt;
    int   h;
    int   v;
    vid_t r;
    ht   = ha + hf + hsw + hb;
    vt   = va + vf + vsw + vb;
    h    = int'(t % ht);
    v    = int'((t / ht) % vt);
    r.h  = 11'(h);
    r.v  = 10'(v);
    r.hs = (h >= ha + hf) && (h < ha + hf + hsw);
    r.vs = (v >= va + vf) && (v < va + vf + vsw);
    r.bl = (h >= ha) || (v >= va);
    return r;
  endfunction

  function automatic vid_t model_xga(input longint t);
    return model(t, 1024, 24, 136, 160, 768, 3, 6, 29);
  endfunction

  function automatic vid_t model_small(input longint t);
    return model(t, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
  endfunction

  function automatic string fmt(input vid_t x);
    return $sformatf("h=%0d v=%0d hs=%b vs=%b bl=%b", x.h, x.v, x.hs, x.vs, x.bl);
  endfunction

  task automatic test_reset();
    reset_xga_n   = 1'b0;
    reset_small_n = 1'b0;
    repeat (5) begin
      @(negedge vclock);
      n_cmp++;
      if (got_xga !== '0) begin n_err++; $display("FAIL reset_hold_xga got %s want all zero", fmt(got_xga)); end
      n_cmp++;
      if (got_small !== '0) begin n_err++; $display("FAIL reset_hold_small got %s want all zero", fmt(got_small)); end
    end
    reset_xga_n   = 1'b1;
    reset_small_n = 1'b1;
    #1;
    n_cmp++;
    if (got_xga !== '0) begin n_err++; $display("FAIL release_xga got %s want all zero", fmt(got_xga)); end
    @(negedge vclock);
    n_cmp++;
    if (vid_xga.hcount !== 11'd1 || vid_xga.vcount !== 10'd0)
      begin n_err++; $display("FAIL first_count_xga got %s want h=1 v=0", fmt(got_xga)); end
    n_cmp++;
    if (vid_small.hcount !== 11'd1 || vid_small.vcount !== 10'd0)
      begin n_err++; $display("FAIL first_count_small got %s want h=1 v=0", fmt(got_small)); end
  endtask

  task automatic test_xga_line();
    vid_t   e;
    longint last_rise = -1;
    int     rises = 0;
    int     hs_cycles = 0;
    logic   prev_hs;
    logic   have;
    logic   want;
    bit     sel;
    string  nm;
    prev_hs = vid_xga.hsync;
    for (int i = 0; i < 2 * X_HT + 16; i++) begin
      @(negedge vclock);
      e = model_xga(t_xga);
      n_cmp++;
      if (got_xga !== e) begin n_err++; $display("FAIL xga_line t=%0d got %s want %s", t_xga, fmt(got_xga), fmt(e)); end
      sel  = 1'b1;
      have = 1'b0;
      want = 1'b0;
      nm   = "";
      case (t_xga)
        1023:    begin nm = "blank_1023";  have = vid_xga.blank; want = 1'b0; end
        1024:    begin nm = "blank_1024";  have = vid_xga.blank; want = 1'b1; end
        1047:    begin nm = "hsync_1047";  have = vid_xga.hsync; want = 1'b0; end
        1048:    begin nm = "hsync_1048";  have = vid_xga.hsync; want = 1'b1; end
        1183:    begin nm = "hsync_1183";  have = vid_xga.hsync; want = 1'b1; end
        1184:    begin nm = "hsync_1184";  have = vid_xga.hsync; want = 1'b0; end
        1344:    begin nm = "line_wrap";   want = 1'b1;
                   have = (vid_xga.hcount === 11'd0) && (vid_xga.vcount === 10'd1) && (vid_xga.blank === 1'b0); end
        default: sel = 1'b0;
      endcase
      if (sel) begin
        n_cmp++;
        if (have !== want) begin n_err++; $display("FAIL %s got %b want %b (%s)", nm, have, want, fmt(got_xga)); end
      end
      if (vid_xga.hsync && !prev_hs) begin
        if (rises > 0) begin
          n_cmp++;
          if (t_xga - last_rise != X_HT)
            begin n_err++; $display("FAIL hsync_period got %0d want %0d", t_xga - last_rise, X_HT); end
        end
        rises++;
        last_rise = t_xga;
      end
      if (t_xga < X_HT && vid_xga.hsync) hs_cycles++;
      prev_hs = vid_xga.hsync;
    end
    n_cmp++;
    if (rises != 2) begin n_err++; $display("FAIL hsync_rises got %0d want 2", rises); end
    n_cmp++;
    if (hs_cycles != 136) begin n_err++; $display("FAIL hsync_width got %0d want 136", hs_cycles); end
  endtask

  task automatic test_xga_midline_reset();
    vid_t e;
    int   guard = 0;
    while (!((t_xga % X_HT) == 500 && t_xga >= X_HT) && guard < 3 * X_HT) begin
      @(negedge vclock);
      guard++;
    end
    n_cmp++;
    if (vid_xga.hcount !== 11'd500) begin n_err++; $display("FAIL reach_500 got h=%0d want 500", vid_xga.hcount); end
    reset_xga_n = 1'b0;
    @(negedge vclock);
    n_cmp++;
    if (got_xga !== '0) begin n_err++; $display("FAIL midline_reset got %s want all zero", fmt(got_xga)); end
    reset_xga_n = 1'b1;
    for (int i = 0; i < 1400; i++) begin
      @(negedge vclock);
      e = model_xga(t_xga);
      n_cmp++;
      if (got_xga !== e) begin n_err++; $display("FAIL midline_resume t=%0d got %s want %s", t_xga, fmt(got_xga), fmt(e)); end
      if (i == 0) begin
        n_cmp++;
        if (vid_xga.hcount !== 11'd1) begin n_err++; $display("FAIL midline_first got h=%0d want 1", vid_xga.hcount); end
      end
    end
  endtask

  task automatic test_small_frames();
    vid_t   e;
    int     line;
    longint last_h = -1;
    longint last_v = -1;
    int     rises_h = 0;
    int     rises_v = 0;
    int     hs_line = 0;
    int     vs_frame = 0;
    int     visible = 0;
    logic   prev_hs;
    logic   prev_vs;
    reset_small_n = 1'b0;
    @(negedge vclock);
    reset_small_n = 1'b1;
    prev_hs = vid_small.hsync;
    prev_vs = vid_small.vsync;
    for (int i = 0; i < 3 * S_FRAME + 4; i++) begin
      @(negedge vclock);
      e    = model_small(t_small);
      line = int'((t_small / S_HT) % S_VT);
      n_cmp++;
      if (got_small !== e) begin n_err++; $display("FAIL small_frame t=%0d got %s want %s", t_small, fmt(got_small), fmt(e)); end
      if (line == 10) begin
        n_cmp++;
        if (vid_small.blank !== 1'b1) begin n_err++; $display("FAIL vblank_line10 got %b want 1", vid_small.blank); end
      end
      if (line >= 12 && line <= 14) begin
        n_cmp++;
        if (vid_small.vsync !== 1'b1) begin n_err++; $display("FAIL vsync_in line=%0d got %b want 1", line, vid_small.vsync); end
      end
      if (line == 11 || line == 15) begin
        n_cmp++;
        if (vid_small.vsync !== 1'b0) begin n_err++; $display("FAIL vsync_out line=%0d got %b want 0", line, vid_small.vsync); end
      end
      if (t_small == S_FRAME - 1) begin
        n_cmp++;
        if (vid_small.hcount !== 11'd27 || vid_small.vcount !== 10'd18)
          begin n_err++; $display("FAIL frame_last got %s want h=27 v=18", fmt(got_small)); end
      end
      if (t_small == S_FRAME) begin
        n_cmp++;
        if (got_small !== '0) begin n_err++; $display("FAIL frame_wrap got %s want all zero", fmt(got_small)); end
      end
      if (vid_small.hsync && !prev_hs) begin
        if (rises_h > 0) begin
          n_cmp++;
          if (t_small - last_h != S_HT) begin n_err++; $display("FAIL small_hsync_period got %0d want %0d", t_small - last_h, S_HT); end
        end
        rises_h++;
        last_h = t_small;
      end
      if (vid_small.vsync && !prev_vs) begin
        if (rises_v > 0) begin
          n_cmp++;
          if (t_small - last_v != S_FRAME) begin n_err++; $display("FAIL vsync_period got %0d want %0d", t_small - last_v, S_FRAME); end
        end
        rises_v++;
        last_v = t_small;
      end
      if (t_small >= S_FRAME && t_small < 2 * S_FRAME) begin
        if (vid_small.vsync) vs_frame++;
        if (!vid_small.blank) visible++;
        if (t_small < S_FRAME + S_HT && vid_small.hsync) hs_line++;
      end
      prev_hs = vid_small.hsync;
      prev_vs = vid_small.vsync;
    end
    n_cmp++;
    if (rises_h != 57) begin n_err++; $display("FAIL small_hsync_rises got %0d want 57", rises_h); end
    n_cmp++;
    if (rises_v != 3) begin n_err++; $display("FAIL vsync_rises got %0d want 3", rises_v); end
    n_cmp++;
    if (hs_line != 4) begin n_err++; $display("FAIL small_hsync_width got %0d want 4", hs_line); end
    n_cmp++;
    if (vs_frame != 84) begin n_err++; $display("FAIL vsync_cycles got %0d want 84", vs_frame); end
    n_cmp++;
    if (visible != 160) begin n_err++; $display("FAIL visible_pixels got %0d want 160", visible); end
  endtask

  task automatic test_small_random_resets();
    vid_t e;
    for (int k = 0; k < 20; k++) begin
      int run  = int'($urandom_range(700, 1));
      int hold = int'($urandom_range(3, 1));
      repeat (run) begin
        @(negedge vclock);
        e = model_small(t_small);
        n_cmp++;
        if (got_small !== e) begin n_err++; $display("FAIL random_run t=%0d got %s want %s", t_small, fmt(got_small), fmt(e)); end
      end
      reset_small_n = 1'b0;
      repeat (hold) begin
        @(negedge vclock);
        n_cmp++;
        if (got_small !== '0) begin n_err++; $display("FAIL random_reset got %s want all zero", fmt(got_small)); end
      end
      reset_small_n = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_xga_line();
    test_xga_midline_reset();
    test_small_frames();
    test_small_random_resets();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
